store_op_gather: RTL and testbench
==================================

// Module: store_op_gather
// PURPOSE
//  Downstream of the lane array on the store path. Collects per-lane store operands.
//  Lanes deliver their slices independently.
//  Emits one aligned NrLane-wide beat per element group to the store unit / memory port.
//  Tracks beat count per store instruction; pulses a done flag with the instruction id.
// PARAMETERS
//  NrLane      core_pkg::NrLane  number of lanes (each slice = vrf_data_t)
//  BufDepth    2                 per-lane operand FIFO depth (>=2, power of 2)
//  BeatW       8                 width of beat counters
// PORTS
//  clk_i             in   1                  clock
//  rst_i             in   1                  async active-high reset
//  req_valid_i       in   1                  new store instruction
//  req_ready_o       out  1                  block idle, can accept req
//  req_beats_i       in   BeatW              beats in instruction (>=1)
//  req_id_i          in   insn_id_t          instruction id
//  store_op_valid_i  in   NrLane             per-lane operand valid
//  store_op_ready_o  out  NrLane             per-lane operand accepted
//  store_op_i        in   NrLane*vrf_data_t  per-lane operand slices
//  beat_valid_o      out  1                  aligned beat available
//  beat_ready_i      in   1                  consumer takes beat
//  beat_data_o       out  NrLane*vrf_data_t  lane i slice at [i]
//  beat_last_o       out  1                  final beat of instruction
//  beat_id_o         out  insn_id_t          id of current instruction
//  done_o            out  1                  1-cycle pulse: instruction complete
//  done_id_o         out  insn_id_t          id for done_o
// BEHAVIOUR
//  Reset (async, rst_i=1): state IDLE, FIFOs empty, counters 0.
//   Reset outputs: req_ready_o=1, store_op_ready_o=0, beat_valid_o=0, beat_last_o=0,
//   done_o=0, beat_id_o/done_id_o=0.
//  FSM IDLE -> ACTIVE on req_valid_i&req_ready_o.
//   Latches id and beats into out_cnt and push_cnt[i] (one per lane).
//   req_ready_o=1 only in IDLE. req_beats_i=0 is illegal (assertion).
//  ACTIVE, per lane i:
//   store_op_ready_o[i] = !fifo_full[i] & push_cnt[i]!=0.
//   On push, push_cnt[i]--. Lanes never receive more than beats pushes.
//  beat_valid_o = all FIFOs non-empty (registered FIFO, no fall-through).
//   Push in cycle t -> beat_valid_o at earliest t+1.
//   beat_valid_o never depends combinationally on beat_ready_i.
//   Once raised, beat_valid_o/beat_data_o are held stable until the handshake.
//  On beat handshake: pop all FIFOs simultaneously, out_cnt--. beat_last_o = (out_cnt==1).
//  Last handshake -> next cycle done_o=1, done_id_o=id, state IDLE. Next req accepted same cycle done_o=1.
//  Simultaneous push+pop on a full FIFO is allowed (count unchanged).
//  FIFO pointers wrap modulo BufDepth. Full = count==BufDepth.
//  Back-pressure: beat_ready_i=0 stalls pops. Lanes fill to BufDepth, then ready drops per lane.
//  Reset mid-instruction: all buffered data discarded, no done pulse.
// STRUCTURE
//  core_pkg: insn_id_t, vrf_data_t, NrLane, new constant StoreBufDepth (default for BufDepth).
//  Sub-module lane_op_fifo (one per lane, generate loop): push/pop/full/empty/head, async reset.
//  Top holds the FSM, push_cnt[NrLane], out_cnt, and id register.
// TESTING
//  1. beats=4, all lanes valid every cycle, beat_ready_i=1
//     -> 4 beats, last on 4th, done_o one cycle later with id.
//  2. beats=3, lane 0 delayed 5 cycles
//     -> other lanes fill to BufDepth then ready=0; beat 0 one cycle after lane 0 push; data aligned.
//  3. beats=8, beat_ready_i=0 for 10 cycles
//     -> beat_valid_o/data stable, all store_op_ready_o=0 after 2 pushes each; all 8 beats delivered in order.
//  4. beats=2, lanes keep valid high after 2 pushes -> store_op_ready_o stays 0; no extra beats.
//  5. rst_i asserted after 2 of 5 beats -> outputs at reset values, no done_o; new req beats=1 completes normally.
//  6. Back-to-back req_valid_i held high -> second req accepted in done_o cycle; ids 3 then 7 reported in order.

Source files
------------

// File: rtl/store_op_gather_pkg.sv
// Shared types and constants for the store-operand gather slice.
package store_op_gather_pkg;

    localparam int unsigned NrLane        = 4;
    localparam int unsigned VrfDataW      = 32;
    localparam int unsigned InsnIdW       = 4;
    localparam int unsigned StoreBufDepth = 2;
    localparam int unsigned StoreBeatW    = 8;

    typedef logic [VrfDataW-1:0] vrf_data_t;
    typedef logic [InsnIdW-1:0]  insn_id_t;

    typedef enum logic {
        IDLE,
        ACTIVE
    } gather_state_e;

endpackage

// File: rtl/store_op_gather_if.sv
// Request, per-lane operand, beat and completion signals of the store gather block.
interface store_op_gather_if
    import store_op_gather_pkg::*;
#(
    parameter int unsigned BeatW = StoreBeatW
) ();

    logic                       req_valid;
    logic                       req_ready;
    logic [BeatW-1:0]           req_beats;
    insn_id_t                   req_id;
    logic [NrLane-1:0]          store_op_valid;
    logic [NrLane-1:0]          store_op_ready;
    vrf_data_t [NrLane-1:0]     store_op;
    logic                       beat_valid;
    logic                       beat_ready;
    vrf_data_t [NrLane-1:0]     beat_data;
    logic                       beat_last;
    insn_id_t                   beat_id;
    logic                       done;
    insn_id_t                   done_id;

    modport master (
        output req_valid, req_beats, req_id, store_op_valid, store_op, beat_ready,
        input  req_ready, store_op_ready, beat_valid, beat_data, beat_last, beat_id,
               done, done_id
    );

    modport slave (
        input  req_valid, req_beats, req_id, store_op_valid, store_op, beat_ready,
        output req_ready, store_op_ready, beat_valid, beat_data, beat_last, beat_id,
               done, done_id
    );

endinterface

// File: rtl/store_op_gather_lane_op_fifo.sv
// Per-lane operand FIFO: registered storage, head is read directly (no fall-through).
module store_op_gather_lane_op_fifo
    import store_op_gather_pkg::*;
#(
    parameter int unsigned Depth = StoreBufDepth
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  vrf_data_t data,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output vrf_data_t head
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    vrf_data_t        mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign pop_en  = pop && !empty;
    // A full FIFO still takes a push when the same cycle pops.
    assign push_en = push && (!full || pop_en);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + PtrW'(1);
            case ({push_en, pop_en})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; reads are gated by the count.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/store_op_gather.sv
// Gathers independently arriving per-lane store operands into aligned beats and
// reports completion of each store instruction.
module store_op_gather
    import store_op_gather_pkg::*;
#(
    parameter int unsigned BufDepth = StoreBufDepth,
    parameter int unsigned BeatW    = StoreBeatW
) (
    input  logic          clk,
    input  logic          rst,
    store_op_gather_if.slave bus
);

    gather_state_e     state_q, state_d;
    logic [BeatW-1:0]  out_cnt_q, out_cnt_d;
    logic [BeatW-1:0]  push_cnt_q [NrLane];
    logic [BeatW-1:0]  push_cnt_d [NrLane];
    insn_id_t          id_q, id_d;
    insn_id_t          done_id_q, done_id_d;
    logic              done_q, done_d;

    logic [NrLane-1:0]      op_ready;
    logic [NrLane-1:0]      push;
    logic [NrLane-1:0]      fifo_full;
    logic [NrLane-1:0]      fifo_empty;
    vrf_data_t [NrLane-1:0] head;
    logic                   beat_valid;
    logic                   beat_fire;

    for (genvar i = 0; i < NrLane; i++) begin : g_lane
        assign op_ready[i] = (state_q == ACTIVE) && !fifo_full[i] && (push_cnt_q[i] != '0);
        assign push[i]     = bus.store_op_valid[i] && op_ready[i];

        store_op_gather_lane_op_fifo #(
            .Depth (BufDepth)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .data  (bus.store_op[i]),
            .pop   (beat_fire),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i]),
            .head  (head[i])
        );
    end

    // A beat exists only once every lane has its slice buffered.
    assign beat_valid = (state_q == ACTIVE) && (fifo_empty == '0);
    assign beat_fire  = beat_valid && bus.beat_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            out_cnt_q  <= '0;
            push_cnt_q <= '{default: '0};
            id_q       <= '0;
            done_q     <= 1'b0;
            done_id_q  <= '0;
        end else begin
            state_q    <= state_d;
            out_cnt_q  <= out_cnt_d;
            push_cnt_q <= push_cnt_d;
            id_q       <= id_d;
            done_q     <= done_d;
            done_id_q  <= done_id_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        out_cnt_d  = out_cnt_q;
        push_cnt_d = push_cnt_q;
        id_d       = id_q;
        done_d     = 1'b0;
        done_id_d  = done_id_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d   = ACTIVE;
                    out_cnt_d = bus.req_beats;
                    id_d      = bus.req_id;
                    for (int unsigned i = 0; i < NrLane; i++) begin
                        push_cnt_d[i] = bus.req_beats;
                    end
                end
            end
            ACTIVE: begin
                for (int unsigned i = 0; i < NrLane; i++) begin
                    if (push[i]) push_cnt_d[i] = push_cnt_q[i] - BeatW'(1);
                end
                if (beat_fire) begin
                    out_cnt_d = out_cnt_q - BeatW'(1);
                    if (out_cnt_q == BeatW'(1)) begin
                        state_d   = IDLE;
                        done_d    = 1'b1;
                        done_id_d = id_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready      = (state_q == IDLE);
    assign bus.store_op_ready = op_ready;
    assign bus.beat_valid     = beat_valid;
    assign bus.beat_data      = head;
    assign bus.beat_last      = (out_cnt_q == BeatW'(1));
    assign bus.beat_id        = id_q;
    assign bus.done           = done_q;
    assign bus.done_id        = done_id_q;

    a_beats_nonzero: assert property (@(posedge clk) disable iff (rst)
        (bus.req_valid && bus.req_ready) |-> (bus.req_beats != '0));

endmodule

// File: tb/tb_store_op_gather.sv
// Directed bench for store_op_gather: table of instruction scenarios plus reset and
// back-to-back sequences.
module tb_store_op_gather;
    import store_op_gather_pkg::*;

    typedef struct {
        int beats;
        int id;
        int stall;    // cycles beat_ready is held low after acceptance
        int delay;    // cycles lane 0 withholds its operands
        int exp_lat;  // edges from acceptance edge to the edge raising done
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    store_op_gather_if #(.BeatW(StoreBeatW)) bus ();

    store_op_gather #(
        .BufDepth (StoreBufDepth),
        .BeatW    (StoreBeatW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vrf_data_t mk(input int id, input int lane, input int beat);
        return {8'(id), 8'(lane), 16'(beat)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".req_ready"},      64'(bus.req_ready), 64'(1));
        chk({tag, ".store_op_ready"}, 64'(bus.store_op_ready), 64'(0));
        chk({tag, ".beat_valid"},     64'(bus.beat_valid), 64'(0));
        chk({tag, ".beat_last"},      64'(bus.beat_last), 64'(0));
        chk({tag, ".done"},           64'(bus.done), 64'(0));
        chk({tag, ".beat_id"},        64'(bus.beat_id), 64'(0));
        chk({tag, ".done_id"},        64'(bus.done_id), 64'(0));
    endtask

    // Drives one instruction from a negedge with the DUT idle; checks every cycle
    // against a per-lane occupancy model and ends at the done pulse.
    task automatic run_txn(input vec_t v, input string tag);
        int                sent [NrLane];
        int                popped;
        int                occ;
        int                lat;
        logic [NrLane-1:0] push_pend;
        logic              fire_pend;
        logic              exp_done;
        logic              exp_bv;
        logic [NrLane-1:0] exp_rdy;

        popped    = 0;
        lat       = -1;
        push_pend = '0;
        fire_pend = 1'b0;
        foreach (sent[i]) sent[i] = 0;

        chk({tag, ".req_ready"}, 64'(bus.req_ready), 64'(1));
        bus.req_valid = 1'b1;
        bus.req_beats = StoreBeatW'(v.beats);
        bus.req_id    = insn_id_t'(v.id);
        @(negedge clk);
        bus.req_valid = 1'b0;

        for (int j = 0; j < 100; j++) begin
            for (int i = 0; i < NrLane; i++) if (push_pend[i]) sent[i]++;
            if (fire_pend) popped++;
            exp_done = fire_pend && (popped == v.beats);
            exp_bv   = !exp_done;
            for (int i = 0; i < NrLane; i++) begin
                occ        = sent[i] - popped;
                exp_rdy[i] = !exp_done && (occ < StoreBufDepth) && (sent[i] < v.beats);
                if (occ == 0) exp_bv = 1'b0;
            end

            chk({tag, ".done"},           64'(bus.done), 64'(exp_done));
            chk({tag, ".store_op_ready"}, 64'(bus.store_op_ready), 64'(exp_rdy));
            chk({tag, ".beat_valid"},     64'(bus.beat_valid), 64'(exp_bv));
            if (exp_bv) begin
                chk({tag, ".beat_last"}, 64'(bus.beat_last), 64'(popped == v.beats - 1));
                chk({tag, ".beat_id"},   64'(bus.beat_id), 64'(v.id));
                for (int i = 0; i < NrLane; i++)
                    chk({tag, ".beat_data"}, 64'(bus.beat_data[i]), 64'(mk(v.id, i, popped)));
            end
            if (exp_done) begin
                chk({tag, ".done_id"}, 64'(bus.done_id), 64'(v.id));
                lat = j;
                break;
            end

            for (int i = 0; i < NrLane; i++) begin
                bus.store_op_valid[i] = (i != 0) || (j >= v.delay);
                bus.store_op[i]       = mk(v.id, i, sent[i]);
            end
            bus.beat_ready = (j >= v.stall);
            push_pend = bus.store_op_valid & bus.store_op_ready;
            fire_pend = bus.beat_valid & bus.beat_ready;
            @(negedge clk);
        end

        chk({tag, ".latency"}, 64'(lat), 64'(v.exp_lat));
        chk({tag, ".beats"},   64'(popped), 64'(v.beats));
        bus.store_op_valid = '0;
        bus.beat_ready     = 1'b0;
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{beats: 4, id: 1, stall: 0,  delay: 0, exp_lat: 5};
        vecs[1] = '{beats: 3, id: 2, stall: 0,  delay: 5, exp_lat: 9};
        vecs[2] = '{beats: 8, id: 4, stall: 10, delay: 0, exp_lat: 18};
        vecs[3] = '{beats: 2, id: 5, stall: 0,  delay: 0, exp_lat: 3};
        vecs[4] = '{beats: 3, id: 6, stall: 3,  delay: 0, exp_lat: 6};

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.req_valid      = 1'b0;
        bus.req_beats      = '0;
        bus.req_id         = '0;
        bus.store_op_valid = '0;
        bus.store_op       = '0;
        bus.beat_ready     = 1'b0;

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[k]) begin
            run_txn(vecs[k], $sformatf("vec%0d", k));
            @(negedge clk);
        end

        // Reset in the middle of a 5-beat instruction, after two beats.
        bus.req_valid = 1'b1;
        bus.req_beats = StoreBeatW'(5);
        bus.req_id    = insn_id_t'(9);
        @(negedge clk);
        bus.req_valid      = 1'b0;
        bus.store_op_valid = '1;
        for (int i = 0; i < NrLane; i++) bus.store_op[i] = mk(9, i, 0);
        bus.beat_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst.beat_valid_before", 64'(bus.beat_valid), 64'(1));
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) begin
            @(negedge clk);
            chk("midrst.no_done", 64'(bus.done), 64'(0));
        end
        rst                = 1'b0;
        bus.store_op_valid = '0;
        bus.beat_ready     = 1'b0;
        @(negedge clk);
        run_txn('{beats: 1, id: 10, stall: 0, delay: 0, exp_lat: 2}, "post_rst");
        @(negedge clk);

        // Back-to-back: request held high, second one taken in the done cycle.
        bus.req_valid      = 1'b1;
        bus.req_beats      = StoreBeatW'(1);
        bus.req_id         = insn_id_t'(3);
        bus.store_op_valid = '1;
        for (int i = 0; i < NrLane; i++) bus.store_op[i] = 32'hC0DE_0000 + 32'(i);
        bus.beat_ready = 1'b1;
        @(negedge clk);
        bus.req_id = insn_id_t'(7);
        chk("b2b.busy_req_ready", 64'(bus.req_ready), 64'(0));
        @(negedge clk);
        chk("b2b.beat_valid_a", 64'(bus.beat_valid), 64'(1));
        chk("b2b.beat_last_a",  64'(bus.beat_last), 64'(1));
        chk("b2b.beat_id_a",    64'(bus.beat_id), 64'(3));
        @(negedge clk);
        chk("b2b.done_a",       64'(bus.done), 64'(1));
        chk("b2b.done_id_a",    64'(bus.done_id), 64'(3));
        chk("b2b.req_ready",    64'(bus.req_ready), 64'(1));
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("b2b.done_clear",   64'(bus.done), 64'(0));
        chk("b2b.beat_id_b",    64'(bus.beat_id), 64'(7));
        @(negedge clk);
        chk("b2b.beat_valid_b", 64'(bus.beat_valid), 64'(1));
        chk("b2b.beat_data_b",  64'(bus.beat_data[NrLane-1]), 64'(32'hC0DE_0000 + 32'(NrLane-1)));
        @(negedge clk);
        chk("b2b.done_b",       64'(bus.done), 64'(1));
        chk("b2b.done_id_b",    64'(bus.done_id), 64'(7));
        bus.store_op_valid = '0;
        bus.beat_ready     = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
